// File: rtl/pool_collector.sv
// Collects one frame of pooled results into a register buffer, then drains it
// in address order over a valid/ready stream, flagging bad, missing or late writes.
module pool_collector #(
   parameter int unsigned IMG = 14,
   parameter int unsigned PAD = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [15:0] wr_addr,
   input  logic [15:0] wr_data,
   input  logic        done_pooling,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic        frame_done,
   output logic        err_addr,
   output logic        err_miss,
   output logic        err_ovr
);

   localparam int unsigned N     = (IMG + 2 * PAD) / 2 - 1;
   localparam int unsigned DEPTH = N * N;
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   rd_nxt;
   logic [DEPTH-1:0]   bitmap_q, bitmap_d;
   logic [15:0]        buf_q [DEPTH];
   logic [15:0]        out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
   logic               busy_q, busy_d;
   logic               frame_done_q, frame_done_d;
   logic               err_addr_q, err_addr_d;
   logic               err_miss_q, err_miss_d;
   logic               err_ovr_q, err_ovr_d;
   logic               wr_ok;
   logic [PTR_W-1:0]   wr_idx;

   assign wr_idx = wr_addr[PTR_W-1:0];
   assign rd_nxt = rd_ptr_q + PTR_W'(1);

   // Next-state and output logic
   always_comb begin
      state_d      = state_q;
      rd_ptr_d     = rd_ptr_q;
      bitmap_d     = bitmap_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      err_addr_d   = err_addr_q;
      err_miss_d   = err_miss_q;
      err_ovr_d    = err_ovr_q;
      wr_ok        = 1'b0;

      case (state_q)
         COLLECT: begin
            if (wr_en) begin
               if (wr_addr < 16'(DEPTH)) begin
                  wr_ok            = 1'b1;
                  bitmap_d[wr_idx] = 1'b1;
               end else begin
                  err_addr_d = 1'b1;
               end
            end
            if (done_pooling) begin
               state_d     = DRAIN;
               busy_d      = 1'b1;
               rd_ptr_d    = '0;
               out_valid_d = 1'b1;
               out_last_d  = (DEPTH == 1);
               // Entry 0 bypasses the buffer so a same-cycle write is seen
               if (wr_ok && (wr_idx == '0)) begin
                  out_data_d = wr_data;
               end else if (bitmap_q[0]) begin
                  out_data_d = buf_q[0];
               end else begin
                  out_data_d = 16'h0000;
                  err_miss_d = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (wr_en || done_pooling) begin
               err_ovr_d = 1'b1;
            end
            if (out_valid_q && out_ready) begin
               if (rd_ptr_q == PTR_W'(DEPTH - 1)) begin
                  state_d      = COLLECT;
                  busy_d       = 1'b0;
                  out_valid_d  = 1'b0;
                  out_last_d   = 1'b0;
                  frame_done_d = 1'b1;
                  bitmap_d     = '0;
               end else begin
                  rd_ptr_d   = rd_nxt;
                  out_last_d = (rd_nxt == PTR_W'(DEPTH - 1));
                  if (bitmap_q[rd_nxt]) begin
                     out_data_d = buf_q[rd_nxt];
                  end else begin
                     out_data_d = 16'h0000;
                     err_miss_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // Control and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= COLLECT;
         rd_ptr_q     <= '0;
         bitmap_q     <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         err_addr_q   <= 1'b0;
         err_miss_q   <= 1'b0;
         err_ovr_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_ptr_q     <= rd_ptr_d;
         bitmap_q     <= bitmap_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         err_addr_q   <= err_addr_d;
         err_miss_q   <= err_miss_d;
         err_ovr_q    <= err_ovr_d;
      end
   end

   // Data buffer is not reset; the bitmap masks stale contents
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         buf_q[wr_idx] <= wr_data;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign err_addr   = err_addr_q;
   assign err_miss   = err_miss_q;
   assign err_ovr    = err_ovr_q;

endmodule
